obf_key_loader: RTL and testbench
=================================

Name: obf_key_loader

Overview:
- Upstream stage for the key-gated c432 netlist. It drives the key inputs s_0/s_1 of the locked core.
- A key arrives serially, MSB first, through a valid-qualified bit stream. The block holds it in a shadow register and commits it to the key outputs atomically.
- After commit it waits a programmable settling interval before asserting key_ready, so the oracle/test harness only samples N223..N432 once the combinational core has settled.

Parameters:
- KEY_W, 2: key width in bits; bit 0 drives s_0, bit 1 drives s_1. Legal range 1..32.
- SETTLE_CYC, 4: cycles between commit and key_ready assertion. Legal range 1..255.
- KEY_RST, 0: value of key_out during and after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle pulse that begins a key load.
- key_sin  in  1  serial key bit.
- key_sin_vld  in  1  key_sin is valid this cycle.
- key_out  out  KEY_W  committed key to the locked core: {..., s_1, s_0}.
- busy  out  1  high in SHIFT or SETTLE.
- key_ready  out  1  committed key has settled; core outputs are valid.
- load_err  out  1  sticky error; cleared by the next load_start.
- load_cnt  out  8  number of successful commits, saturating at 255.

Behaviour:
- Reset: all outputs update asynchronously.
  - key_out=KEY_RST, busy=0, key_ready=0, load_err=0, load_cnt=0.
  - Shadow register cleared; state=IDLE.
- States are IDLE, SHIFT, SETTLE, READY, ERROR.
- IDLE:
  - load_start -> SHIFT. Bit counter cleared, load_err cleared, shadow cleared.
  - key_sin_vld without load_start is ignored.
- SHIFT:
  - On each key_sin_vld: shadow={shadow[KEY_W-2:0],key_sin}, bit counter increments.
  - Cycles without valid simply stall. There is no timeout.
  - On the cycle the KEY_W-th bit is accepted, the next edge does three things: key_out<=shadow (including that bit), settle counter<=SETTLE_CYC-1, state->SETTLE.
  - key_out never shows a partial key.
- SETTLE:
  - Counter decrements each cycle.
  - When the counter is 0: key_ready<=1, load_cnt increments (saturating), state->READY.
  - Commit to key_ready therefore takes exactly SETTLE_CYC cycles.
- READY:
  - key_ready held high. key_sin_vld is ignored.
  - load_start -> SHIFT and key_ready drops on the same edge. key_out keeps the old key until the new commit.
- load_start during SHIFT or SETTLE:
  - The load restarts: bit counter and shadow are cleared, state=SHIFT.
  - key_ready stays 0 and key_out is unchanged.
- load_start and key_sin_vld in the same cycle: load_start wins and that bit is discarded.
- key_ready is high only in READY; busy is high only in SHIFT or SETTLE.
- Reset mid-load (any state): immediate return to reset values. The previously committed key is lost and key_out=KEY_RST.
- ERROR: reachable only with the optional feature. key_out=KEY_RST, load_err=1. Exits only via load_start or rst.

Optional Feature:
- Macro: OBF_KEY_PARITY_EN.
- Defined:
  - SHIFT expects KEY_W+1 valid bits; the last is an even-parity bit over the KEY_W key bits.
  - On the parity bit: if the parity matches, commit as above; if it does not, state->ERROR, load_err=1, key_out<=KEY_RST, load_cnt unchanged.
- Not defined:
  - Exactly KEY_W bits are taken, with no parity check.
  - ERROR is unreachable and load_err is tied 0.

Test Plan:
1. Reset release, no stimulus -> key_out=0, busy=0, key_ready=0, load_cnt=0 held for 20 cycles.
2. load_start, then bits 1,0 on consecutive valid cycles (KEY_W=2, SETTLE_CYC=4) -> key_out=2'b10 one edge after the 2nd bit; key_ready=1 exactly 4 cycles later; load_cnt=1; busy low when key_ready rises.
3. load_start, bit 1, 3 idle cycles, bit 1 -> key_out stays at the old value until the 2nd bit, then 2'b11; the stalls add no extra settle cycles.
4. In READY with key 2'b10, load_start, one bit, then load_start again, then bits 0,1 -> key_ready falls on the first load_start; key_out stays 2'b10 until commit of 2'b01.
5. rst asserted mid-SETTLE -> outputs go to reset values asynchronously, before the next clock edge; key_out=KEY_RST.
6. OBF_KEY_PARITY_EN: bits 1,1,parity 1 -> load_err=1, key_out=0, load_cnt unchanged. Bits 1,1,parity 0 -> commit 2'b11 and key_ready after SETTLE_CYC.

Source files
------------

// File: rtl/obf_key_loader.sv
// obf_key_loader
// Loads a serial key (MSB first) into a shadow register and commits it
// atomically to the key inputs of the locked c432 core. After each commit it
// waits SETTLE_CYC cycles before raising key_ready, so the core outputs are
// only sampled once the combinational logic has settled.
//
// Optional feature (macro OBF_KEY_PARITY_EN): an extra even-parity bit follows
// the KEY_W key bits. A parity mismatch enters ERROR, sets load_err and forces
// key_out to KEY_RST. Without the macro, exactly KEY_W bits are taken and
// load_err is tied 0.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   load_start   in   one-cycle pulse that (re)starts a key load
//   key_sin      in   serial key bit
//   key_sin_vld  in   key_sin is valid this cycle
//   key_out      out  committed key {..., s_1, s_0}
//   busy         out  high in SHIFT or SETTLE
//   key_ready    out  committed key has settled (high only in READY)
//   load_err     out  sticky error, cleared by the next load_start
//   load_cnt     out  successful commits, saturating at 255
//
// Handshake: the stream has no backpressure. A bit is consumed on every rising
// edge where key_sin_vld is high while in SHIFT and load_start is low; valid
// bits in any other state, or alongside load_start, are dropped.
module obf_key_loader #(
  parameter int              KEY_W      = 2,
  parameter int              SETTLE_CYC = 4,
  parameter logic [KEY_W-1:0] KEY_RST   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             key_sin,
  input  logic             key_sin_vld,
  output logic [KEY_W-1:0] key_out,
  output logic             busy,
  output logic             key_ready,
  output logic             load_err,
  output logic [7:0]       load_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_SETTLE,
    S_READY,
    S_ERROR
  } state_t;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYC - 1);

  state_t           r_state;
  logic [KEY_W-1:0] r_shadow;
  logic [5:0]       r_bit_cnt;
  logic [7:0]       r_settle;
  logic [KEY_W-1:0] r_key_out;
  logic             r_busy;
  logic             r_key_ready;
  logic [7:0]       r_load_cnt;
  logic [KEY_W-1:0] w_shadow_nxt;

  // A 1-bit key has no upper bits to shift up.
  generate
    if (KEY_W == 1) begin : g_shift_1
      assign w_shadow_nxt = key_sin;
    end else begin : g_shift_n
      assign w_shadow_nxt = {r_shadow[KEY_W-2:0], key_sin};
    end
  endgenerate

`ifdef OBF_KEY_PARITY_EN
  localparam logic [5:0] PARITY_IDX = 6'(KEY_W);
  logic r_par;   // running XOR of the key bits received so far
  logic r_err;
  assign load_err = r_err;
`else
  localparam logic [5:0] LAST_KEY_BIT = 6'(KEY_W - 1);
  assign load_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shadow    <= '0;
      r_bit_cnt   <= '0;
      r_settle    <= '0;
      r_key_out   <= KEY_RST;
      r_busy      <= 1'b0;
      r_key_ready <= 1'b0;
      r_load_cnt  <= '0;
`ifdef OBF_KEY_PARITY_EN
      r_par       <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else if (load_start) begin
      // Start or restart from any state; key_out keeps the last commit.
      r_state     <= S_SHIFT;
      r_shadow    <= '0;
      r_bit_cnt   <= '0;
      r_busy      <= 1'b1;
      r_key_ready <= 1'b0;
`ifdef OBF_KEY_PARITY_EN
      r_par       <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (key_sin_vld) begin
`ifdef OBF_KEY_PARITY_EN
            if (r_bit_cnt == PARITY_IDX) begin
              // Even parity: key bits XOR parity bit must be 0.
              if ((r_par ^ key_sin) == 1'b0) begin
                r_key_out <= r_shadow;
                r_settle  <= SETTLE_INIT;
                r_state   <= S_SETTLE;
              end else begin
                r_key_out <= KEY_RST;
                r_err     <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= S_ERROR;
              end
            end else begin
              r_shadow  <= w_shadow_nxt;
              r_par     <= r_par ^ key_sin;
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
`else
            r_shadow  <= w_shadow_nxt;
            r_bit_cnt <= r_bit_cnt + 6'd1;
            if (r_bit_cnt == LAST_KEY_BIT) begin
              // Commit includes the bit accepted this cycle.
              r_key_out <= w_shadow_nxt;
              r_settle  <= SETTLE_INIT;
              r_state   <= S_SETTLE;
            end
`endif
          end
        end
        S_SETTLE: begin
          if (r_settle == 8'd0) begin
            r_key_ready <= 1'b1;
            r_busy      <= 1'b0;
            if (r_load_cnt != 8'hFF) r_load_cnt <= r_load_cnt + 8'd1;
            r_state     <= S_READY;
          end else begin
            r_settle <= r_settle - 8'd1;
          end
        end
        default: ;  // IDLE, READY, ERROR wait for load_start
      endcase
    end
  end

  assign key_out   = r_key_out;
  assign busy      = r_busy;
  assign key_ready = r_key_ready;
  assign load_cnt  = r_load_cnt;

endmodule

// File: tb/tb_obf_key_loader.sv
// Directed bench for obf_key_loader with KEY_W=2, SETTLE_CYC=4, KEY_RST=0.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at that same point, i.e. away from the active edge.
module tb_obf_key_loader;

  localparam int KEY_W      = 2;
  localparam int SETTLE_CYC = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_start = 1'b0;
  logic             key_sin = 1'b0;
  logic             key_sin_vld = 1'b0;
  logic [KEY_W-1:0] key_out;
  logic             busy;
  logic             key_ready;
  logic             load_err;
  logic [7:0]       load_cnt;

  int checks = 0;
  int errors = 0;

  obf_key_loader #(
    .KEY_W(KEY_W),
    .SETTLE_CYC(SETTLE_CYC),
    .KEY_RST(2'b00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_start(load_start),
    .key_sin(key_sin),
    .key_sin_vld(key_sin_vld),
    .key_out(key_out),
    .busy(busy),
    .key_ready(key_ready),
    .load_err(load_err),
    .load_cnt(load_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse load_start, then shift in key (MSB first, plus parity if enabled),
  // inserting 'stall' idle cycles after the first bit. key_out must hold
  // old_key until the edge after the last bit.
  task automatic send_key(input logic [1:0] key, input int stall, input logic [1:0] old_key);
    logic [2:0] seq;
    int nb;
    seq = {key[1], key[0], ^key};
`ifdef OBF_KEY_PARITY_EN
    nb = 3;
`else
    nb = 2;
`endif
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_start_edge: key_ready=%b busy=%b, required 0/1", key_ready, busy);
    end
    for (int j = 0; j < nb; j++) begin
      key_sin = seq[2-j];
      key_sin_vld = 1'b1;
      step();
      key_sin_vld = 1'b0;
      if (j < nb - 1) begin
        checks++;
        if (key_out !== old_key) begin
          errors++;
          $display("FAIL partial_key bit%0d: key_out=%b, required %b", j, key_out, old_key);
        end
        if (j == 0) begin
          for (int s = 0; s < stall; s++) begin
            step();
            checks++;
            if (key_out !== old_key) begin
              errors++;
              $display("FAIL stall_key cyc%0d: key_out=%b, required %b", s, key_out, old_key);
            end
          end
        end
      end else begin
        checks++;
        if (key_out !== key || busy !== 1'b1 || key_ready !== 1'b0) begin
          errors++;
          $display("FAIL commit: key_out=%b busy=%b rdy=%b, required %b/1/0", key_out, busy, key_ready, key);
        end
      end
    end
  endtask

  // From the commit edge: key_ready must rise exactly SETTLE_CYC edges later.
  task automatic wait_ready(input logic [7:0] exp_cnt, input logic [1:0] exp_key);
    for (int c = 1; c < SETTLE_CYC; c++) begin
      step();
      checks++;
      if (key_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL settle cyc%0d: key_ready=%b busy=%b, required 0/1", c, key_ready, busy);
      end
    end
    step();
    checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || load_cnt !== exp_cnt || key_out !== exp_key) begin
      errors++;
      $display("FAIL ready: rdy=%b busy=%b cnt=%0d key=%b, required 1/0/%0d/%b",
               key_ready, busy, load_cnt, key_out, exp_cnt, exp_key);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    // stray valid bits in IDLE must be ignored
    for (int c = 0; c < 20; c++) begin
      key_sin = 1'b1;
      key_sin_vld = (c % 3 == 0);
      step();
      checks++;
      if (key_out !== 2'b00 || busy !== 1'b0 || key_ready !== 1'b0 ||
          load_cnt !== 8'd0 || load_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: key=%b busy=%b rdy=%b cnt=%0d err=%b, required 00/0/0/0/0",
                 c, key_out, busy, key_ready, load_cnt, load_err);
      end
    end
    key_sin_vld = 1'b0;
  endtask

  task automatic test_basic_load();
    send_key(2'b10, 0, 2'b00);
    wait_ready(8'd1, 2'b10);
  endtask

  task automatic test_stall();
    send_key(2'b11, 3, 2'b10);
    wait_ready(8'd2, 2'b11);
    // valid bits in READY are ignored
    key_sin = 1'b0;
    key_sin_vld = 1'b1;
    step();
    step();
    key_sin_vld = 1'b0;
    checks++;
    if (key_ready !== 1'b1 || key_out !== 2'b11 || load_cnt !== 8'd2) begin
      errors++;
      $display("FAIL ready_hold: rdy=%b key=%b cnt=%0d, required 1/11/2", key_ready, key_out, load_cnt);
    end
  endtask

  task automatic test_restart();
    send_key(2'b10, 0, 2'b11);
    wait_ready(8'd3, 2'b10);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b1 || key_out !== 2'b10) begin
      errors++;
      $display("FAIL restart_drop: rdy=%b busy=%b key=%b, required 0/1/10", key_ready, busy, key_out);
    end
    key_sin = 1'b1;
    key_sin_vld = 1'b1;
    step();
    // restart with a simultaneous valid bit: that bit must be discarded
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    key_sin_vld = 1'b0;
    checks++;
    if (key_out !== 2'b10 || key_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_mid: key=%b rdy=%b busy=%b, required 10/0/1", key_out, key_ready, busy);
    end
    send_key(2'b01, 0, 2'b10);
    wait_ready(8'd4, 2'b01);
  endtask

  task automatic test_reset_mid_settle();
    send_key(2'b11, 0, 2'b01);
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (key_out !== 2'b00 || busy !== 1'b0 || key_ready !== 1'b0 ||
        load_cnt !== 8'd0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: key=%b busy=%b rdy=%b cnt=%0d err=%b, required 00/0/0/0/0",
               key_out, busy, key_ready, load_cnt, load_err);
    end
    step();
    rst = 1'b0;
    step();
  endtask

`ifdef OBF_KEY_PARITY_EN
  task automatic test_parity();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      key_sin = 1'b1;
      key_sin_vld = 1'b1;
      step();
    end
    key_sin_vld = 1'b0;
    checks++;
    if (load_err !== 1'b1 || key_out !== 2'b00 || load_cnt !== 8'd0 ||
        busy !== 1'b0 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL parity_err: err=%b key=%b cnt=%0d busy=%b rdy=%b, required 1/00/0/0/0",
               load_err, key_out, load_cnt, busy, key_ready);
    end
    send_key(2'b11, 0, 2'b00);
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_clear: load_err=%b, required 0", load_err);
    end
    wait_ready(8'd1, 2'b11);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_stall();
    test_restart();
    test_reset_mid_settle();
`ifdef OBF_KEY_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
